// File: rtl/arith_pkg.sv
// Shared types and width/extension helpers for the operand accumulator.
// Combinational helpers only; no latency or backpressure of their own.
package arith_pkg;

  typedef enum logic {ACCUM = 1'b0, DONE = 1'b1} acc_state_t;

  localparam int MAX_W = 64;

  function automatic int sum_width(input int width, input int num_ops, input bit signed_mode);
    return width + $clog2(num_ops) + (signed_mode ? 1 : 0);
  endfunction

  // Extends the low 'width' bits of value to sum_w bits; bits at and above sum_w are zero.
  function automatic logic [MAX_W-1:0] ext_to(input int sum_w, input int width,
                                              input logic [MAX_W-1:0] value,
                                              input bit signed_mode);
    logic [MAX_W-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_W; i++) begin
      if (i < sum_w) r[i] = (i < width) ? value[i] : (signed_mode & value[width-1]);
    end
    return r;
  endfunction

endpackage

// File: rtl/btn_edge_pulse.sv
// Button conditioner: two-flop synchroniser plus rising-edge detect, one pulse per press.
// Latency: pulse is high 3 clocks after btn_raw rises; no backpressure, a held button yields one pulse.
module btn_edge_pulse (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse
);

  logic sync_q1, sync_q2, prev_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_q1 <= 1'b0;
      sync_q2 <= 1'b0;
      prev_q  <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      sync_q1 <= btn_raw;
      sync_q2 <= sync_q1;
      prev_q  <= sync_q2;
      pulse   <= sync_q2 & ~prev_q;
    end
  end

endmodule

// File: rtl/multi_operand_accumulator.sv
// Sums NUM_OPS operands taken over valid/ready, then holds the result with done high until clear.
// Latency: sum updates 1 cycle after accept; in_ready drops once the last operand lands, inputs ignored in DONE.
module multi_operand_accumulator
  import arith_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NUM_OPS = 5,
  parameter int SIGNED  = 0,
  parameter int SUM_W   = sum_width(WIDTH, NUM_OPS, SIGNED != 0),
  parameter int CNT_W   = $clog2(NUM_OPS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic [SUM_W-1:0] sum,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_OPS - 1);

  acc_state_t       state;
  logic [MAX_W-1:0] din_w;
  logic [MAX_W-1:0] ext_w;
  logic [SUM_W-1:0] operand;
  logic             accept;
  logic             unused_ext_hi;

  assign din_w         = MAX_W'(in_data);
  assign ext_w         = ext_to(SUM_W, WIDTH, din_w, SIGNED != 0);
  assign operand       = ext_w[SUM_W-1:0];
  assign unused_ext_hi = ^ext_w[MAX_W-1:SUM_W];
  assign accept        = (state == ACCUM) && in_valid;

  // clear takes priority over an accept in the same cycle, so that operand is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      state    <= ACCUM;
      sum      <= '0;
      count    <= '0;
      done     <= 1'b0;
      in_ready <= 1'b1;
    end else if (accept) begin
      sum   <= sum + operand;
      count <= count + 1'b1;
      if (count == LAST_IDX) begin
        state    <= DONE;
        done     <= 1'b1;
        in_ready <= 1'b0;
      end
    end
  end

endmodule
